// File: rtl/fifo_stream_reader.sv
// Read-side drain engine: pops a synchronous FIFO and re-presents
// the words on a valid/ready stream through a 2-entry skid buffer.
module fifo_stream_reader #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  input  logic [WIDTH-1:0]     fifo_dout,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic [WIDTH-1:0]     data_out,
  output logic [CNT_WIDTH-1:0] pop_count
);

  logic [1:0]       occ;
  logic             inflight;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;

  logic             accept;
  logic             pop;
  logic [1:0]       level;
  logic [WIDTH-1:0] head_d;
  logic [WIDTH-1:0] tail_d;

  assign data_valid = (occ != 2'd0);
  assign data_out   = head_q;
  assign accept     = data_valid & data_ready;
  assign pop        = fifo_rd_en & ~fifo_empty;

  // Occupancy after this edge, counting the word already in flight
  always_comb begin
    level = occ + {1'b0, inflight} - {1'b0, accept};
  end

  // Pop only when the word it returns is guaranteed a free slot
  always_comb begin
    fifo_rd_en = ~rst & ~fifo_empty & (level < 2'd2);
  end

  // Retire the head on accept, then drop the arriving word at the tail
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (accept) begin
      head_d = tail_q;
    end
    if (inflight) begin
      if (level == 2'd1) begin
        head_d = fifo_dout;
      end else begin
        tail_d = fifo_dout;
      end
    end
  end

  // Skid-buffer, in-flight and pop-counter state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ       <= 2'd0;
      inflight  <= 1'b0;
      head_q    <= '0;
      tail_q    <= '0;
      pop_count <= '0;
    end else begin
      occ      <= level;
      inflight <= pop;
      head_q   <= head_d;
      tail_q   <= tail_d;
      if (pop) begin
        pop_count <= pop_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural FIFO
// in front and a capture queue behind.
module tb_fifo_stream_reader;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [W-1:0]  fifo_dout;
  logic          data_valid;
  logic          data_ready;
  logic [W-1:0]  data_out;
  logic [CW-1:0] pop_count;

  logic          push_en;
  logic [W-1:0]  push_data;
  logic [W-1:0]  fq[$];
  logic [W-1:0]  got[$];
  int            viol;
  int            vectors;
  int            miscompares;

  fifo_stream_reader #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_dout  (fifo_dout),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .data_out   (data_out),
    .pop_count  (pop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural FIFO: registered read data, reset together with the DUT
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fq.delete();
      fifo_dout  <= '0;
      fifo_empty <= 1'b1;
    end else begin
      if (fifo_rd_en && fq.size() > 0) fifo_dout <= fq.pop_front();
      if (push_en) fq.push_back(push_data);
      fifo_empty <= (fq.size() == 0);
    end
  end

  // Capture accepted words and catch pops against an empty FIFO
  always @(posedge clk) begin
    if (!rst && data_valid && data_ready) got.push_back(data_out);
    if (!rst && fifo_rd_en && fifo_empty) viol++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    viol        = 0;
    rst         = 1'b1;
    data_ready  = 1'b0;
    push_en     = 1'b0;
    push_data   = '0;

    // Reset state
    tick(); tick(); tick();
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_valid", 32'(data_valid), 32'd0);
    chk("rst_dout",  32'(data_out),   32'd0);
    chk("rst_cnt",   32'(pop_count),  32'd0);
    rst = 1'b0;
    tick();

    // Single word
    push_en    = 1'b1;
    push_data  = 8'hA5;
    data_ready = 1'b1;
    tick();
    push_en = 1'b0;
    chk("sw_rd_en_n",   32'(fifo_rd_en), 32'd1);
    chk("sw_valid_n",   32'(data_valid), 32'd0);
    tick();
    chk("sw_rd_en_n1",  32'(fifo_rd_en), 32'd0);
    chk("sw_valid_n1",  32'(data_valid), 32'd0);
    tick();
    chk("sw_valid_n2",  32'(data_valid), 32'd1);
    chk("sw_data_n2",   32'(data_out),   32'h0A5);
    chk("sw_cnt",       32'(pop_count),  32'd1);
    tick();
    chk("sw_valid_n3",  32'(data_valid), 32'd0);

    // Streaming: one word per cycle
    push_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push_data = W'(i);
      tick();
      if (i >= 2) begin
        chk("st_valid", 32'(data_valid), 32'd1);
        chk("st_data",  32'(data_out),   32'(i - 2));
      end
    end
    push_en = 1'b0;
    for (int j = 6; j < 8; j++) begin
      tick();
      chk("st_valid", 32'(data_valid), 32'd1);
      chk("st_data",  32'(data_out),   32'(j));
    end
    tick();
    chk("st_valid_end", 32'(data_valid), 32'd0);
    chk("st_cnt",       32'(pop_count),  32'd9);

    // Back-pressure: only two words captured, head held
    data_ready = 1'b0;
    push_en    = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push_data = W'(8'h10 + i);
      tick();
    end
    push_en = 1'b0;
    tick(); tick(); tick();
    chk("bp_rd_en",  32'(fifo_rd_en), 32'd0);
    chk("bp_valid",  32'(data_valid), 32'd1);
    chk("bp_data",   32'(data_out),   32'h10);
    chk("bp_cnt",    32'(pop_count),  32'd11);
    tick(); tick();
    chk("bp_hold",   32'(data_out),   32'h10);
    chk("bp_rd_en2", 32'(fifo_rd_en), 32'd0);

    // Toggled ready drains all eight; pop count wraps 16 -> 0 -> 1
    got.delete();
    for (int k = 0; k < 40; k++) begin
      data_ready = (k % 2 == 0);
      tick();
    end
    chk("tg_count", 32'(got.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < got.size()) chk("tg_data", 32'(got[i]), 32'(8'h10 + i));
    end
    chk("wrap_cnt", 32'(pop_count), 32'd1);

    // Interleaved writes with random ready
    got.delete();
    for (int i = 0; i < 40; i++) begin
      push_en    = (i % 2 == 0);
      push_data  = W'(8'h40 + i / 2);
      data_ready = 1'($urandom_range(0, 1));
      tick();
    end
    push_en    = 1'b0;
    data_ready = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    chk("rnd_count", 32'(got.size()), 32'd20);
    for (int i = 0; i < 20; i++) begin
      if (i < got.size()) chk("rnd_data", 32'(got[i]), 32'(8'h40 + i));
    end
    chk("rnd_no_empty_pop", 32'(viol), 32'd0);
    chk("rnd_cnt", 32'(pop_count), 32'd5);

    // Asynchronous reset mid-cycle with the buffer full
    data_ready = 1'b0;
    push_en    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_data = W'(8'h80 + i);
      tick();
    end
    push_en = 1'b0;
    tick(); tick(); tick();
    chk("pre_rst_valid", 32'(data_valid), 32'd1);
    chk("pre_rst_data",  32'(data_out),   32'h80);
    #3 rst = 1'b1;
    #1;
    chk("ar_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("ar_valid", 32'(data_valid), 32'd0);
    chk("ar_data",  32'(data_out),   32'd0);
    chk("ar_cnt",   32'(pop_count),  32'd0);
    tick(); tick();
    rst = 1'b0;
    data_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("post_rst_valid", 32'(data_valid), 32'd0);
    chk("post_rst_cnt",   32'(pop_count),  32'd0);
    chk("post_rst_rd_en", 32'(fifo_rd_en), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
